// File: rtl/pipeline_cpu_pkg.sv
`default_nettype none
// ==========================================================================
// pipeline_cpu_pkg: opcodes, ALU/forward encodings and control struct
// Revision 1.0
// ==========================================================================
package pipeline_cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_MUL = 6'h18;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_MUL = 3'd4
  } alu_op_e;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  typedef struct packed {
    logic    reg_write;
    logic    mem_to_reg;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Unknown opcodes and unknown R-type functs decode to an all-zero NOP.
  function automatic ctrl_t decode(input logic [5:0] op, input logic [5:0] funct);
    ctrl_t c;
    c = CTRL_NOP;
    case (op)
      OP_RTYPE: begin
        c.reg_write = 1'b1;
        case (funct)
          FN_ADD:  c.alu_op = ALU_ADD;
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_AND:  c.alu_op = ALU_AND;
          FN_OR:   c.alu_op = ALU_OR;
          FN_MUL:  c.alu_op = ALU_MUL;
          default: c.reg_write = 1'b0;
        endcase
      end
      OP_ADDI: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.mem_read   = 1'b1;
        c.alu_src    = 1'b1;
      end
      OP_SW: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_cpu_hazard_forward_unit.sv
`default_nettype none
// ==========================================================================
// hazard_forward_unit: EX operand forward selects and load-use stall
// Revision 1.0
// ==========================================================================
module hazard_forward_unit
  import pipeline_cpu_pkg::*;
(
  input  logic       id_ex_mem_read,
  input  logic [4:0] id_ex_rs,
  input  logic [4:0] id_ex_rt,
  input  logic [4:0] if_id_rs,
  input  logic [4:0] if_id_rt,
  input  logic       ex_mem_reg_write,
  input  logic [4:0] ex_mem_dest,
  input  logic       mem_wb_reg_write,
  input  logic [4:0] mem_wb_dest,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       MUX_Control_hazard_o
);

  logic ex_mem_fwd;
  logic mem_wb_fwd;

  assign ex_mem_fwd = ex_mem_reg_write && (ex_mem_dest != 5'd0);
  assign mem_wb_fwd = mem_wb_reg_write && (mem_wb_dest != 5'd0);

  // The younger result (EX/MEM) shadows the older one (MEM/WB).
  always_comb begin
    fwd_a = FWD_REG;
    if (ex_mem_fwd && ex_mem_dest == id_ex_rs)      fwd_a = FWD_EXMEM;
    else if (mem_wb_fwd && mem_wb_dest == id_ex_rs) fwd_a = FWD_MEMWB;
    fwd_b = FWD_REG;
    if (ex_mem_fwd && ex_mem_dest == id_ex_rt)      fwd_b = FWD_EXMEM;
    else if (mem_wb_fwd && mem_wb_dest == id_ex_rt) fwd_b = FWD_MEMWB;
  end

  assign MUX_Control_hazard_o = id_ex_mem_read &&
                                ((id_ex_rt == if_id_rs) || (id_ex_rt == if_id_rt));

endmodule
`default_nettype wire

// File: rtl/pipeline_cpu.sv
`default_nettype none
// ==========================================================================
// pipeline_cpu: five-stage in-order MIPS-subset CPU with local memories
// Revision 1.0
// ==========================================================================
module pipeline_cpu
  import pipeline_cpu_pkg::*;
#(
  parameter int IMEM_WORDS = 256,
  parameter int DMEM_BYTES = 32
) (
  input logic clk_i,
  input logic rst_i,
  input logic start_i
);

  localparam int IA_W = $clog2(IMEM_WORDS);
  localparam int DA_W = $clog2(DMEM_BYTES);

  logic [31:0] instr, if_id_instr, if_id_pc4;
  logic [31:0] rs_data, rt_data, id_imm, branch_target, jump_target;
  logic [4:0]  id_rs, id_rt, id_dest;
  ctrl_t       id_ctrl, id_ex_ctrl, ex_mem_ctrl, mem_wb_ctrl;
  logic [31:0] id_ex_rs_data, id_ex_rt_data, id_ex_imm;
  logic [4:0]  id_ex_rs, id_ex_rt, id_ex_dest, ex_mem_dest, mem_wb_dest;
  logic [31:0] op_a, op_b, store_data, alu_result;
  logic [31:0] ex_mem_alu, ex_mem_store, mem_rdata, mem_wb_alu, mem_wb_rdata, wb_data;
  logic [DA_W-3:0] mem_word;
  logic [1:0]  fwd_a, fwd_b;
  logic        stall, wb_we;

  // ---------------- IF ----------------
  if (1) begin : PC
    logic [31:0] pc_o;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) pc_o <= '0;
      else if (!stall) begin
        if (Flush.flush_o) pc_o <= Control.jump_o ? jump_target : branch_target;
        else if (start_i)  pc_o <= pc_o + 32'd4;
      end
    end
  end

  if (1) begin : Instruction_Memory
    logic [31:0] memory [0:IMEM_WORDS-1];
  end
  assign instr = Instruction_Memory.memory[PC.pc_o[IA_W+1:2]];

  // While idle, IF/ID takes bubbles so a held PC is not re-issued.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      if_id_instr <= '0;
      if_id_pc4   <= '0;
    end else if (!stall) begin
      if (Flush.flush_o || !start_i) begin
        if_id_instr <= '0;
        if_id_pc4   <= '0;
      end else begin
        if_id_instr <= instr;
        if_id_pc4   <= PC.pc_o + 32'd4;
      end
    end
  end

  // ---------------- ID ----------------
  assign id_rs         = if_id_instr[25:21];
  assign id_rt         = if_id_instr[20:16];
  assign id_ctrl       = decode(if_id_instr[31:26], if_id_instr[5:0]);
  assign id_dest       = (if_id_instr[31:26] == OP_RTYPE) ? if_id_instr[15:11] : id_rt;
  assign id_imm        = {{16{if_id_instr[15]}}, if_id_instr[15:0]};
  assign branch_target = if_id_pc4 + {id_imm[29:0], 2'b00};
  assign jump_target   = {if_id_pc4[31:28], if_id_instr[25:0], 2'b00};

  if (1) begin : Registers
    logic [31:0] register [0:31];
    always_ff @(posedge clk_i) begin
      if (wb_we) register[mem_wb_dest] <= wb_data;
    end
  end

  assign rs_data = (id_rs == 5'd0) ? 32'd0 :
                   (wb_we && mem_wb_dest == id_rs) ? wb_data : Registers.register[id_rs];
  assign rt_data = (id_rt == 5'd0) ? 32'd0 :
                   (wb_we && mem_wb_dest == id_rt) ? wb_data : Registers.register[id_rt];

  if (1) begin : Control
    logic jump_o, branch_o;
    assign jump_o   = (if_id_instr[31:26] == OP_J);
    assign branch_o = (if_id_instr[31:26] == OP_BEQ);
  end

  // A pending load-use stall defers the redirect to the next cycle.
  if (1) begin : Flush
    logic flush_o;
    assign flush_o = !stall && (Control.jump_o || (Control.branch_o && rs_data == rt_data));
  end

  hazard_forward_unit HazardDetection (
    .id_ex_mem_read       (id_ex_ctrl.mem_read),
    .id_ex_rs             (id_ex_rs),
    .id_ex_rt             (id_ex_rt),
    .if_id_rs             (id_rs),
    .if_id_rt             (id_rt),
    .ex_mem_reg_write     (ex_mem_ctrl.reg_write),
    .ex_mem_dest          (ex_mem_dest),
    .mem_wb_reg_write     (mem_wb_ctrl.reg_write),
    .mem_wb_dest          (mem_wb_dest),
    .fwd_a                (fwd_a),
    .fwd_b                (fwd_b),
    .MUX_Control_hazard_o (stall)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      id_ex_ctrl    <= CTRL_NOP;
      id_ex_rs_data <= '0;
      id_ex_rt_data <= '0;
      id_ex_imm     <= '0;
      id_ex_rs      <= '0;
      id_ex_rt      <= '0;
      id_ex_dest    <= '0;
    end else begin
      id_ex_ctrl    <= stall ? CTRL_NOP : id_ctrl;
      id_ex_rs_data <= rs_data;
      id_ex_rt_data <= rt_data;
      id_ex_imm     <= id_imm;
      id_ex_rs      <= id_rs;
      id_ex_rt      <= id_rt;
      id_ex_dest    <= id_dest;
    end
  end

  // ---------------- EX ----------------
  always_comb begin
    op_a = id_ex_rs_data;
    case (fwd_a)
      FWD_EXMEM: op_a = ex_mem_alu;
      FWD_MEMWB: op_a = wb_data;
      default:   ;
    endcase
    store_data = id_ex_rt_data;
    case (fwd_b)
      FWD_EXMEM: store_data = ex_mem_alu;
      FWD_MEMWB: store_data = wb_data;
      default:   ;
    endcase
  end

  assign op_b = id_ex_ctrl.alu_src ? id_ex_imm : store_data;

  always_comb begin
    alu_result = op_a + op_b;
    case (id_ex_ctrl.alu_op)
      ALU_SUB: alu_result = op_a - op_b;
      ALU_AND: alu_result = op_a & op_b;
      ALU_OR:  alu_result = op_a | op_b;
      ALU_MUL: alu_result = op_a * op_b;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_mem_ctrl  <= CTRL_NOP;
      ex_mem_alu   <= '0;
      ex_mem_store <= '0;
      ex_mem_dest  <= '0;
    end else begin
      ex_mem_ctrl  <= id_ex_ctrl;
      ex_mem_alu   <= alu_result;
      ex_mem_store <= store_data;
      ex_mem_dest  <= id_ex_dest;
    end
  end

  // ---------------- MEM ----------------
  assign mem_word = ex_mem_alu[DA_W-1:2];

  if (1) begin : DataMemory
    logic [7:0] memory [0:DMEM_BYTES-1];
    always_ff @(posedge clk_i) begin
      if (ex_mem_ctrl.mem_write) begin
        memory[{mem_word, 2'd0}] <= ex_mem_store[7:0];
        memory[{mem_word, 2'd1}] <= ex_mem_store[15:8];
        memory[{mem_word, 2'd2}] <= ex_mem_store[23:16];
        memory[{mem_word, 2'd3}] <= ex_mem_store[31:24];
      end
    end
  end

  assign mem_rdata = {DataMemory.memory[{mem_word, 2'd3}], DataMemory.memory[{mem_word, 2'd2}],
                      DataMemory.memory[{mem_word, 2'd1}], DataMemory.memory[{mem_word, 2'd0}]};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_wb_ctrl  <= CTRL_NOP;
      mem_wb_alu   <= '0;
      mem_wb_rdata <= '0;
      mem_wb_dest  <= '0;
    end else begin
      mem_wb_ctrl  <= ex_mem_ctrl;
      mem_wb_alu   <= ex_mem_alu;
      mem_wb_rdata <= mem_rdata;
      mem_wb_dest  <= ex_mem_dest;
    end
  end

  // ---------------- WB ----------------
  assign wb_data = mem_wb_ctrl.mem_to_reg ? mem_wb_rdata : mem_wb_alu;
  assign wb_we   = mem_wb_ctrl.reg_write && (mem_wb_dest != 5'd0);

  logic unused_bits;
  assign unused_bits = ^{if_id_instr[10:6], ex_mem_ctrl, mem_wb_ctrl};

endmodule
`default_nettype wire

// File: tb/tb_pipeline_cpu.sv
`default_nettype none
// ==========================================================================
// tb_pipeline_cpu: directed programs, writeback scoreboard, final-state checks
// Revision 1.0
// ==========================================================================
module tb_pipeline_cpu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;

  always #5 clk = ~clk;

  pipeline_cpu #(.IMEM_WORDS(256), .DMEM_BYTES(32)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .start_i (start)
  );

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] val;
  } wb_t;

  wb_t exp_q[$];
  int  vectors = 0;
  int  miscompares = 0;
  int  stalls = 0;
  int  flushes = 0;

  function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%08h), want %0d (0x%08h)", name, act, act, exp, exp);
    end
  endtask

  // Monitor: every architectural register write is popped against the scoreboard.
  wb_t got;
  always @(negedge clk) begin
    if (!rst) begin
      if (dut.HazardDetection.MUX_Control_hazard_o) stalls++;
      if (dut.Flush.flush_o) flushes++;
      if (dut.wb_we) begin
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_wb: got write $%0d=%0d, want no write",
                   dut.mem_wb_dest, dut.wb_data);
        end else begin
          got = exp_q.pop_front();
          check("wb_reg", {27'd0, dut.mem_wb_dest}, {27'd0, got.rd});
          check($sformatf("wb_val_r%0d", got.rd), dut.wb_data, got.val);
        end
      end
    end
  end

  task automatic begin_test();
    rst = 1'b1;
    start = 1'b0;
    exp_q.delete();
    for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] <= 32'd0;
    for (int i = 0; i < 32; i++)  dut.Registers.register[i] <= 32'd0;
    for (int i = 0; i < 32; i++)  dut.DataMemory.memory[i] <= 8'd0;
    @(posedge clk); #1;
    stalls = 0;
    flushes = 0;
  endtask

  task automatic put(input int word, input logic [31:0] w);
    dut.Instruction_Memory.memory[word] <= w;
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] val);
    wb_t e;
    e.rd = rd;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic run_prog(input int n);
    rst = 1'b0;
    start = 1'b1;
    repeat (n) @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("pending_wb", exp_q.size(), 32'd0);
  endtask

  initial begin
    // Pure forwarding chain
    begin_test();
    put(0, i_op(6'h08, 0, 8, 16'd5));
    put(1, r_op(8, 8, 9, 6'h20));
    put(2, r_op(9, 8, 10, 6'h22));
    expect_wb(8, 5); expect_wb(9, 10); expect_wb(10, 5);
    run_prog(20);
    check("fwd_stalls", stalls, 0);
    check("fwd_flushes", flushes, 0);

    // Load-use stall, then store with forwarded data
    begin_test();
    dut.DataMemory.memory[0] <= 8'd5;
    put(0, i_op(6'h23, 0, 8, 16'd0));
    put(1, r_op(8, 8, 9, 6'h20));
    put(2, i_op(6'h2B, 0, 9, 16'd4));
    expect_wb(8, 5); expect_wb(9, 10);
    run_prog(20);
    check("lu_stalls", stalls, 1);
    check("lu_flushes", flushes, 0);
    check("sw_word", {dut.DataMemory.memory[7], dut.DataMemory.memory[6],
                      dut.DataMemory.memory[5], dut.DataMemory.memory[4]}, 32'd10);

    // Taken beq skips one instruction
    begin_test();
    put(0, i_op(6'h08, 0, 8, 16'd1));
    put(4, i_op(6'h04, 8, 8, 16'd1));
    put(5, i_op(6'h08, 0, 9, 16'd7));
    put(6, i_op(6'h08, 0, 10, 16'd3));
    expect_wb(8, 1); expect_wb(10, 3);
    run_prog(20);
    check("beq_t_r9", dut.Registers.register[9], 32'd0);
    check("beq_t_flushes", flushes, 1);

    // Not-taken beq: no penalty
    begin_test();
    put(0, i_op(6'h08, 0, 8, 16'd1));
    put(4, i_op(6'h04, 8, 0, 16'd1));
    put(5, i_op(6'h08, 0, 9, 16'd7));
    put(6, i_op(6'h08, 0, 10, 16'd3));
    expect_wb(8, 1); expect_wb(9, 7); expect_wb(10, 3);
    run_prog(20);
    check("beq_nt_flushes", flushes, 0);

    // Jump to address 16
    begin_test();
    put(0, {6'h02, 26'd4});
    put(1, i_op(6'h08, 0, 9, 16'd9));
    put(4, i_op(6'h08, 0, 11, 16'd11));
    expect_wb(11, 11);
    run_prog(20);
    check("j_r9", dut.Registers.register[9], 32'd0);
    check("j_flushes", flushes, 1);

    // mul, write to $0, and no forwarding from a $0 destination
    begin_test();
    dut.Registers.register[8] <= 32'd5;
    dut.Registers.register[9] <= 32'd6;
    put(0, r_op(8, 9, 12, 6'h18));
    put(1, r_op(8, 9, 0, 6'h18));
    put(2, r_op(12, 0, 13, 6'h20));
    expect_wb(12, 30); expect_wb(13, 30);
    run_prog(20);
    check("r0_zero", dut.Registers.register[0], 32'd0);

    // and/or, plus EX/MEM priority over MEM/WB
    begin_test();
    put(0, i_op(6'h08, 0, 8, 16'd12));
    put(1, i_op(6'h08, 0, 9, 16'd10));
    put(2, r_op(8, 9, 10, 6'h24));
    put(3, r_op(8, 9, 11, 6'h25));
    put(4, i_op(6'h08, 0, 8, 16'd1));
    put(5, i_op(6'h08, 0, 8, 16'd2));
    put(6, r_op(8, 8, 14, 6'h20));
    expect_wb(8, 12); expect_wb(9, 10); expect_wb(10, 8); expect_wb(11, 14);
    expect_wb(8, 1); expect_wb(8, 2); expect_wb(14, 4);
    run_prog(24);

    // Idle hold, run, asynchronous reset mid-run
    begin_test();
    put(0, i_op(6'h08, 0, 8, 16'd5));
    put(1, r_op(8, 8, 9, 6'h20));
    put(2, r_op(9, 8, 10, 6'h22));
    expect_wb(8, 5); expect_wb(9, 10); expect_wb(10, 5);
    check("pc_reset", dut.PC.pc_o, 32'd0);
    rst = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check($sformatf("pc_idle%0d", i), dut.PC.pc_o, 32'd0);
    end
    start = 1'b1;
    repeat (10) @(posedge clk);
    #1 check("pc_run", dut.PC.pc_o, 32'd40);
    rst = 1'b1;
    #1 check("pc_async_rst", dut.PC.pc_o, 32'd0);
    check("pending_wb_rst", exp_q.size(), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("hold_r8", dut.Registers.register[8], 32'd5);
    check("hold_r9", dut.Registers.register[9], 32'd10);
    check("hold_r10", dut.Registers.register[10], 32'd5);
    check("pc_after_rst", dut.PC.pc_o, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
